muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit with its own HI/LO register pair.
- Replaces the single-cycle mult/div paths of the main ALU with a 1-bit-per-cycle shift/add and shift/subtract engine.
- Sits beside the ALU in the EX stage. The control unit issues an op with a start pulse, stalls on busy, and reads HI/LO for mfhi/mflo.

---
 rtl/muldiv_sequencer.sv | 132 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  wr_hi,
  input  logic                  wr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  // state | meaning
  // S_IDLE | waiting for start; mthi/mtlo writes allowed
  // S_RUN  | one multiply/divide iteration per cycle
  // S_FIX  | sign correction or divide-by-zero substitution
  // S_WB   | commit accumulator to HI/LO, done pulses next cycle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_WB} state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_div, neg_main, neg_rem, div0;
  logic [W-1:0]         opnd, a_raw, acc_hi, acc_lo;

  logic                 sgn;
  logic [W-1:0]         a_abs, b_abs;
  logic [W:0]           mul_sum, div_shift;
  logic                 div_ge;
  logic [2*W-1:0]       prod_neg;

  assign sgn       = ~op[0];
  assign a_abs     = (sgn && A[W-1]) ? -A : A;
  assign b_abs     = (sgn && B[W-1]) ? -B : B;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign prod_neg  = -{acc_hi, acc_lo};
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST_ITER) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div0     <= 1'b0;
      opnd     <= '0;
      a_raw    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else begin
      done <= (state == S_WB);
      unique case (state)
        S_IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            // multiply keeps the multiplier in acc_lo; divide keeps the dividend there
            is_div   <= op[1];
            neg_main <= sgn & (A[W-1] ^ B[W-1]);
            neg_rem  <= sgn & op[1] & A[W-1];
            div0     <= op[1] & (B == '0);
            a_raw    <= A;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_abs : b_abs;
            opnd     <= op[1] ? b_abs : a_abs;
            cnt      <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (is_div) begin
            acc_hi <= div_ge ? (div_shift[W-1:0] - opnd) : div_shift[W-1:0];
            acc_lo <= {acc_lo[W-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
          end
        end
        S_FIX: begin
          if (div0) begin
            acc_hi <= a_raw;
            acc_lo <= '1;
          end else if (is_div) begin
            if (neg_main) acc_lo <= -acc_lo;
            if (neg_rem)  acc_hi <= -acc_hi;
          end else if (neg_main) begin
            {acc_hi, acc_lo} <= prod_neg;
          end
        end
        S_WB: begin
          hi <= acc_hi;
          lo <= acc_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: timing, sign rules, corner cases,
// mthi/mtlo writes, busy-time filtering and asynchronous reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] A = '0, B = '0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_hi = '0, model_lo = '0;

  muldiv_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Starts at a negedge, returns at the negedge where done is high.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    int n;
    bit hold_ok, early_done;
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; A = ~a; B = 32'h0;
    n = 0; hold_ok = 1'b1; early_done = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (done !== 1'b0) early_done = 1'b1;
      if (hi !== model_hi || lo !== model_lo) hold_ok = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 34) begin n_fail++; $display("FAIL %s busy_cycles got %0d want 34", name, n); end
    n_checks++;
    if (early_done !== 1'b0) begin n_fail++; $display("FAIL %s early_done got 1 want 0", name); end
    n_checks++;
    if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL %s hilo_hold got changed want %h/%h", name, model_hi, model_lo); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s done got %b want 1", name, done); end
    n_checks++;
    if (hi !== eh) begin n_fail++; $display("FAIL %s hi got %h want %h", name, hi, eh); end
    n_checks++;
    if (lo !== el) begin n_fail++; $display("FAIL %s lo got %h want %h", name, lo, el); end
    model_hi = eh; model_lo = el;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b want 0", done); end
  endtask

  task automatic test_signed();
    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
    @(negedge clk);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    @(negedge clk);
    do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2");
    @(negedge clk);
    do_op(2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6, "mult_neg2xneg3");
    @(negedge clk);
  endtask

  task automatic test_div_corner();
    do_op(2'd3, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by_zero");
    @(negedge clk);
    do_op(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by_zero");
    @(negedge clk);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_overflow");
    @(negedge clk);
    do_op(2'd3, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, "divu_big");
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int n;
    op = 2'd1; A = 32'd3; B = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      start = (n == 5 || n == 20);
      op = 2'd2; A = 32'd100; B = 32'd3;
      wr_hi = (n == 10); wr_lo = (n == 10); wdata = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    n_checks++;
    if (n !== 34) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d want 34", n); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %b want 1", done); end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'd12) begin n_fail++; $display("FAIL ignore_result got %h/%h want 00000000/0000000c", hi, lo); end
    model_hi = 32'h0; model_lo = 32'd12;
    // start on the done cycle must be accepted
    do_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "back_to_back");
    @(negedge clk);
  endtask

  task automatic test_mtx();
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    n_checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_mtlo got %h/%h want 12345678/12345678", hi, lo); end
    wr_lo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    wr_lo = 1'b0;
    n_checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo_only got %h/%h want 12345678/cafef00d", hi, lo); end
    model_hi = 32'h1234_5678; model_lo = 32'hCAFE_F00D;
  endtask

  task automatic test_reset_mid();
    bit saw;
    op = 2'd1; A = 32'd3; B = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL midreset_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done got activity want none"); end
    do_op(2'd1, 32'd2, 32'd3, 32'd0, 32'd6, "after_reset");
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_corner();
    test_busy_ignore();
    test_mtx();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
